// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle RV32M/RV64M multiply-divide unit.
// Registered single-cycle multiplier plus a restoring radix-2 divider
// (one quotient bit per cycle), behind valid/ready handshakes on both sides.
module mdu_iter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           operator_i,
    input  logic [WORD_SIZE-1:0] operand_a_i,
    input  logic [WORD_SIZE-1:0] operand_b_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] result_o
);

    localparam int W  = WORD_SIZE;
    localparam int CW = $clog2(WORD_SIZE) + 1;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;      // multiplicand, or dividend/quotient shift register
    logic [W-1:0]    b_q;      // multiplier, or divisor magnitude
    logic [W-1:0]    rem_q;    // partial remainder (always below the divisor)
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic            sign_r;

    // Accept-time decode: special divide results and operand magnitudes.
    logic            div_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    special_res;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;

    // Multiplier datapath.
    logic            mul_a_sign;
    logic            mul_b_sign;
    logic [2*W-1:0]  mul_a_wide;
    logic [2*W-1:0]  mul_b_wide;
    logic [2*W-1:0]  product;
    logic [W-1:0]    mul_res;

    // Divider step and sign fix-up.
    logic [W:0]      rem_shift;
    logic [W:0]      diff;
    logic            q_bit;
    logic [W-1:0]    rem_next;
    logic [W-1:0]    quot_next;
    logic [W-1:0]    quot_fix;
    logic [W-1:0]    rem_fix;
    logic [W-1:0]    fix_res;

    // Combinational decode of the incoming request and of each datapath step.
    // NOTE: every signal gets a value on every path through always_comb;
    // a missing default here would infer a latch.
    always_comb begin
        div_signed  = ~operator_i[0];
        div_zero    = (operand_b_i == '0);
        div_ovf     = div_signed && (operand_a_i == MOST_NEG) && (operand_b_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = operator_i[1] ? operand_a_i : '1;
        end else if (div_ovf) begin
            special_res = operator_i[1] ? '0 : operand_a_i;
        end
        a_mag = (div_signed && operand_a_i[W-1]) ? -operand_a_i : operand_a_i;
        b_mag = (div_signed && operand_b_i[W-1]) ? -operand_b_i : operand_b_i;

        // Sign-extending to 2W bits gives the exact (W+1)x(W+1) signed product
        // modulo 2^(2W), which holds both result words.
        mul_a_sign = ((op_q == 3'b001) || (op_q == 3'b010)) && a_q[W-1];
        mul_b_sign = (op_q == 3'b001) && b_q[W-1];
        mul_a_wide = {{W{mul_a_sign}}, a_q};
        mul_b_wide = {{W{mul_b_sign}}, b_q};
        product    = mul_a_wide * mul_b_wide;
        mul_res    = (op_q[1:0] == 2'b00) ? product[W-1:0] : product[2*W-1:W];

        // Restoring step: bring in the next dividend bit, subtract if it fits.
        rem_shift = {rem_q, a_q[W-1]};
        diff      = rem_shift - {1'b0, b_q};
        q_bit     = ~diff[W];
        rem_next  = q_bit ? diff[W-1:0] : rem_shift[W-1:0];
        quot_next = {a_q[W-2:0], q_bit};

        quot_fix = sign_q ? -a_q : a_q;
        rem_fix  = sign_r ? -rem_q : rem_q;
        fix_res  = op_q[1] ? rem_fix : quot_fix;
    end

    // Control FSM with registered handshake outputs and result.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i && ready_o) begin
                        op_q    <= operator_i;
                        ready_o <= 1'b0;
                        if (!operator_i[2]) begin
                            a_q   <= operand_a_i;
                            b_q   <= operand_b_i;
                            state <= S_MUL;
                        end else if (div_zero || div_ovf) begin
                            result_o <= special_res;
                            valid_o  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            a_q    <= a_mag;
                            b_q    <= b_mag;
                            rem_q  <= '0;
                            cnt_q  <= CW'(W - 1);
                            sign_q <= div_signed && (operand_a_i[W-1] ^ operand_b_i[W-1]);
                            sign_r <= div_signed && operand_a_i[W-1];
                            state  <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        result_o <= mul_res;
                        valid_o  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        rem_q <= rem_next;
                        a_q   <= quot_next;
                        if (cnt_q == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (flush_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        result_o <= fix_res;
                        valid_o  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A handoff and a flush both end the operation the same way.
                    if (ready_i || flush_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised, multi-cycle RV32M/RV64M multiply-divide unit for the ri5cy execute stage. It replaces the single-cycle combinational divide path with a restoring radix-2 iterative divider and a registered multiplier, accessed through valid/ready handshakes. It implements full RISC-V M semantics, including division-by-zero and signed-overflow results, high-word multiplies, and a flush for pipeline kills.

Parameters:
WORD_SIZE, 32, operand/result width in bits (32 or 64).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
valid_i  in  1  request valid.
ready_o  out  1  unit can accept a request (high only in IDLE).
operator_i  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
operand_a_i  in  WORD_SIZE  rs1 (dividend / multiplicand).
operand_b_i  in  WORD_SIZE  rs2 (divisor / multiplier).
flush_i  in  1  abort the in-flight operation.
valid_o  out  1  result_o valid.
ready_i  in  1  consumer accepts the result.
result_o  out  WORD_SIZE  result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready_o=1, valid_o=0, result_o=0, all internal registers=0. Reset mid-operation discards the operation without a result.
- Accept: a request is taken on a rising edge with valid_i&&ready_o. Operands and operator are latched, so the inputs are don't-care afterwards.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE -> MUL for ops 000-011.
- IDLE -> DONE directly for special divides, with result computed at accept:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give operand_a.
  - DIV/REM with a=most-negative and b=-1: DIV gives a; REM gives 0.
- IDLE -> DIV for all other ops 100-111.
- MUL (1 cycle): 2*WORD_SIZE-bit product with a signed for MULH/MULHSU and b signed for MULH only. Operands are extended to WORD_SIZE+1 bits. MUL selects the low word; MULH/MULHSU/MULHU select the high word. Then -> DONE.
- DIV (WORD_SIZE cycles): operates on magnitudes. Signed ops take absolute values, with sign_q = a[MSB]^b[MSB] and sign_r = a[MSB]. One quotient bit per cycle, MSB first, via a shift/subtract on a WORD_SIZE+1-bit partial remainder. An iteration counter of $clog2(WORD_SIZE)+1 bits counts WORD_SIZE-1 down to 0; at 0 -> FIX.
- FIX (1 cycle): negate the quotient if sign_q, negate the remainder if sign_r (signed ops only). Select quotient or remainder per operator. Then -> DONE.
- DONE: valid_o=1 and result_o is held stable until ready_i. On valid_o&&ready_i the unit returns to IDLE the next edge, with ready_o=1 that edge. There is no back-to-back accept in the same cycle as result handoff.
- Latency, counted in rising edges from the accept edge to the first cycle with valid_o=1:
  - multiply: 2.
  - normal divide: WORD_SIZE+2.
  - special divide: 1.
- Throughput: one operation in flight.
- Backpressure: with ready_i=0, DONE holds indefinitely and the result is unchanged.
- flush_i: in MUL/DIV/FIX/DONE, the next edge goes to IDLE with valid_o=0 and no result emitted. flush_i in IDLE is ignored and does not block a simultaneous accept. flush_i together with valid_o&&ready_i completes the handoff and then returns to IDLE.
- valid_i while busy is ignored (ready_o=0). The requester must hold the request until it is accepted.
- result_o changes only on the DONE-entry edge and on reset.

Test Plan:
- WORD_SIZE=32, MULH a=0xFFFFFFFE (-2), b=3 -> result 0xFFFFFFFF, valid_o 2 edges after accept. MUL on the same operands -> 0xFFFFFFFA.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU on the same operands -> 0xFFFFFFFE. MUL -> 0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2. valid_o exactly 34 edges after accept.
- DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each after 1 edge. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0. ready_o stays 0 until handoff.
- DIV issued, flush_i pulsed at iteration 10 -> valid_o never rises, ready_o=1 next edge. A new MUL 6*7 accepted immediately -> 42. Separately, rst_i asserted mid-DIV -> outputs go to reset values immediately (asynchronous), with no result.
- Backpressure: hold ready_i=0 for 20 cycles in DONE -> valid_o=1 and result_o stable throughout, valid_i pulses ignored. Raise ready_i -> one handoff, then IDLE.
